// File: rtl/lab_pkg.sv
// Shared types for the circle arc plotter: FSM states, octant slot numbering
// and the clear colour.
package lab_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INIT,
    DRAW,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    SLOT_0,
    SLOT_1,
    SLOT_2,
    SLOT_3,
    SLOT_4,
    SLOT_5,
    SLOT_6,
    SLOT_7
  } slot_e;

  localparam logic [31:0] BLACK = '0;

endpackage

// File: rtl/circle_octant_gen.sv
// Midpoint circle stepper: walks one octant, presenting one of the eight
// mirrored offsets per cycle and advancing the iteration in the slot-7 cycle.
module circle_octant_gen
  import lab_pkg::*;
#(
  parameter int RADIUS_W = 8,
  localparam int C_W = RADIUS_W + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [RADIUS_W-1:0]   radius,
  output slot_e                 slot,
  output logic signed [C_W-1:0] dx,
  output logic signed [C_W-1:0] dy,
  output logic                  last_iter
);

  localparam logic signed [C_W-1:0] ONE = C_W'(1);

  logic signed [C_W-1:0] ox, oy, crit;
  logic signed [C_W-1:0] ox_n, oy_n, crit_n;

  // crit <= 0 is tested as "negative or zero" to keep it a pure bit test
  always_comb begin
    oy_n = oy + ONE;
    if (crit[C_W-1] || crit == '0) begin
      ox_n   = ox;
      crit_n = crit + (oy_n <<< 1) + ONE;
    end else begin
      ox_n   = ox - ONE;
      crit_n = crit + ((oy_n - ox_n) <<< 1) + ONE;
    end
    last_iter = (slot == SLOT_7) && (oy_n > ox_n);
  end

  always_comb begin
    dx = '0;
    dy = '0;
    case (slot)
      SLOT_0: begin dx =  ox; dy =  oy; end
      SLOT_1: begin dx =  oy; dy =  ox; end
      SLOT_2: begin dx = -oy; dy =  ox; end
      SLOT_3: begin dx = -ox; dy =  oy; end
      SLOT_4: begin dx = -ox; dy = -oy; end
      SLOT_5: begin dx = -oy; dy = -ox; end
      SLOT_6: begin dx =  oy; dy = -ox; end
      SLOT_7: begin dx =  ox; dy = -oy; end
      default: begin dx = '0; dy = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ox   <= '0;
      oy   <= '0;
      crit <= '0;
      slot <= SLOT_0;
    end else if (load) begin
      ox   <= {3'b000, radius};
      oy   <= '0;
      crit <= ONE - {3'b000, radius};
      slot <= SLOT_0;
    end else if (step) begin
      slot <= slot_e'(slot + 3'd1);
      if (slot == SLOT_7) begin
        ox   <= ox_n;
        oy   <= oy_n;
        crit <= crit_n;
      end
    end
  end

endmodule

// File: rtl/circle_arc_plotter.sv
// Clipped circle / octant-arc drawer with optional full-screen clear; one pixel
// per cycle, Moore outputs, no backpressure (VGA sink always ready).
module circle_arc_plotter
  import lab_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3,
  parameter int RADIUS_W = 8,
  localparam int X_W = $clog2(SCREEN_W),
  localparam int Y_W = $clog2(SCREEN_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                skip_clear,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [RADIUS_W-1:0] radius,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [7:0]          octant_mask,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int C_W = RADIUS_W + 3;
  localparam logic signed [C_W-1:0] W_S = C_W'(SCREEN_W);
  localparam logic signed [C_W-1:0] H_S = C_W'(SCREEN_H);

  state_e                state, state_nxt;
  logic [X_W-1:0]        cx_q, clr_x;
  logic [Y_W-1:0]        cy_q, clr_y;
  logic [RADIUS_W-1:0]   r_q;
  logic [COLOUR_W-1:0]   col_q;
  logic [7:0]            mask_q;
  logic                  clr_last, last_iter, on_screen;
  slot_e                 slot;
  logic signed [C_W-1:0] dx, dy, px, py;

  circle_octant_gen #(.RADIUS_W(RADIUS_W)) u_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (state == INIT),
    .step      (state == DRAW),
    .radius    (r_q),
    .slot      (slot),
    .dx        (dx),
    .dy        (dy),
    .last_iter (last_iter)
  );

  assign clr_last = (clr_x == X_W'(SCREEN_W - 1)) && (clr_y == Y_W'(SCREEN_H - 1));

  // Full signed range is kept so off-screen points clip instead of wrapping
  assign px = $signed({{(C_W-X_W){1'b0}}, cx_q}) + dx;
  assign py = $signed({{(C_W-Y_W){1'b0}}, cy_q}) + dy;
  assign on_screen = !px[C_W-1] && (px < W_S) && !py[C_W-1] && (py < H_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cx_q   <= '0;
      cy_q   <= '0;
      r_q    <= '0;
      col_q  <= '0;
      mask_q <= '0;
      clr_x  <= '0;
      clr_y  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        clr_x <= '0;
        clr_y <= '0;
        if (start) begin
          cx_q   <= centre_x;
          cy_q   <= centre_y;
          r_q    <= radius;
          col_q  <= colour;
          mask_q <= octant_mask;
        end
      end else if (state == CLEAR) begin
        if (clr_y == Y_W'(SCREEN_H - 1)) begin
          clr_y <= '0;
          clr_x <= clr_x + X_W'(1);
        end else begin
          clr_y <= clr_y + Y_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = skip_clear ? INIT : CLEAR;
      CLEAR:   if (clr_last) state_nxt = INIT;
      INIT:    state_nxt = DRAW;
      DRAW:    if (last_iter) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      CLEAR: begin
        vga_x      = clr_x;
        vga_y      = clr_y;
        vga_colour = COLOUR_W'(BLACK);
        vga_plot   = 1'b1;
      end
      DRAW: begin
        vga_x      = px[X_W-1:0];
        vga_y      = py[Y_W-1:0];
        vga_colour = col_q;
        vga_plot   = mask_q[slot] && on_screen;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/circle_arc_plotter.md
# circle_arc_plotter

- Parametrised successor to the lab's fixed-size shape drawers.
- Draws a clipped circle outline, or any subset of its eight octant arcs, in one colour to a SCREEN_W×SCREEN_H VGA pixel interface.
- Can optionally clear the screen to black first.
- Sits between the lab top level (or triangle/circle test sequences) and the VGA adapter, and uses the same start/done handshake as the existing drawers.

## Interface
Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- COLOUR_W, 3, colour bits
- RADIUS_W, 8, radius bits
- X_W = $clog2(SCREEN_W), Y_W = $clog2(SCREEN_H) are derived, not overridable.

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- skip_clear  in  1  when 1 at start, the CLEAR phase is bypassed.
- centre_x  in  X_W  circle centre x.
- centre_y  in  Y_W  circle centre y.
- radius  in  RADIUS_W  circle radius in pixels.
- colour  in  COLOUR_W  outline colour.
- octant_mask  in  8  bit i enables octant slot i.
- done  out  1  completion flag.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write strobe for the current pixel.

## Operation
States: IDLE, CLEAR, INIT, DRAW, DONE.
- **IDLE:** when start=1, latch centre_x, centre_y, radius, colour, octant_mask and skip_clear.
  - Go to INIT if skip_clear=1, otherwise to CLEAR.
  - Input changes after the latch are ignored until the next IDLE.
- **CLEAR:** one pixel per cycle, colour 0, vga_plot=1.
  - Order is x outer, y inner: (0,0), (0,1) … (0,H-1), (1,0) … (W-1,H-1).
  - Lasts exactly W*H cycles, then goes to INIT.
- **INIT:** one cycle, vga_plot=0. Loads oy=0, ox=radius, crit=1-radius.
- **DRAW:** midpoint algorithm. Each iteration is 8 cycles, one per slot s=0..7:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-oy, cy+ox)
  - 3: (cx-ox, cy+oy)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- Per-slot plot rule:
  - vga_plot=1 only if octant_mask[s]=1 and 0≤x<SCREEN_W and 0≤y<SCREEN_H.
  - Otherwise the slot still consumes its cycle with vga_plot=0.
  - vga_x/vga_y carry the truncated coordinate either way.
- Iteration update, in the slot-7 cycle:
  - oy+=1.
  - If crit≤0: crit+=2·oy+1 (new oy).
  - Else: ox-=1, then crit+=2·(oy−ox)+1 (new values).
- After the update: if oy>ox, go to DONE; else run the next iteration.
- **DONE:** done=1, vga_plot=0. Return to IDLE when start=0.
  - Holding start=1 never retriggers; start must be seen low for at least one cycle first.
- Arithmetic is signed, RADIUS_W+3 bits wide for coordinates and crit. Negative or oversized coordinates are clipped, never wrapped.
- radius=0: one iteration, 8 slots all at (cx,cy).

## Timing
- Reset values: done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0; state=IDLE.
  - Reset mid-operation aborts on the next edge.
  - A start held during reset is ignored until the first cycle after rst falls.
- Outputs are Moore, decoded from registered state and counters only. There is no combinational path from inputs to outputs.
- start=1 sampled at edge k:
  - The first CLEAR pixel is presented during cycle k+1.
  - With skip_clear=1, INIT is cycle k+1 and slot 0 is cycle k+2.
- Total busy cycles = (skip_clear ? 0 : W·H) + 1 + 8·N, where N is the number of iterations.
- done rises in the cycle after the last slot-7 cycle. It falls in the cycle after start is sampled low.
- The VGA adapter is assumed always ready. There is no backpressure.

## Structure
- lab_pkg holds:
  - the state enum: IDLE, CLEAR, INIT, DRAW, DONE;
  - the octant slot enum;
  - the constant BLACK = '0.
- One sub-module, circle_octant_gen: holds the ox/oy/crit registers and the slot counter, and produces slot offsets plus a last-iteration flag.
- The top level contains the FSM, the clear counters, clipping and output muxing.

## Test plan
- **Reset:** assert rst for 3 cycles with start=1 → all outputs 0, no plot, no done until rst falls.
- **Clear:** skip_clear=0, radius=0, octant_mask=8'h00.
  - Expect exactly 19200 vga_plot pulses, colour 0, each pixel once, in the specified order.
  - Then 9 cycles with plot=0, then done=1.
- **Radius 0:** centre (80,60), radius 0, mask 8'hFF, colour 5, skip_clear=1.
  - Expect 8 plots of (80,60) colour 5 in cycles k+2..k+9; done=1 at k+10.
- **Full circle:** centre (80,60), radius 40, mask 8'hFF, skip_clear=1.
  - Plotted set must match the reference model, including (120,60), (80,100), (40,60), (80,20).
  - Cycle count must be 1+8N.
  - Repeat with rst pulsed mid-DRAW → next-cycle IDLE and zero outputs.
- **Corner clip:** centre (0,0), radius 10, mask 8'hFF.
  - Only on-screen pixels plotted, including (10,0) and (0,10).
  - No plot with x≥150 or y≥110 (proves no wraparound).
- **Single octant:** centre (80,60), radius 5, mask 8'h01.
  - Plots only slot-0 pixels starting at (85,60).
  - start held high after done → no restart. Drop start for 1 cycle → done=0 and IDLE, then a new start is accepted.
